// File: rtl/cdb_reservation_station_pkg.sv
// Shared types for the CDB reservation station and its operand capture slices.
// The tag width is shared with the CDB arbiter's rs_id output.
package cdb_reservation_station_pkg;

  localparam int CDB_TAG_WIDTH  = 3;
  localparam int RS_VALUE_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    EXEC,
    RESULT
  } rs_state_t;

  typedef struct packed {
    logic                      ready;
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [RS_VALUE_WIDTH-1:0] value;
  } rs_operand_t;

endpackage

// File: rtl/cdb_reservation_station_operand_capture.sv
// One source operand register of the reservation station.
// Captures a CDB broadcast on tag match, both at dispatch (bypass) and while waiting.
module rs_operand_capture
  import cdb_reservation_station_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [TAG_WIDTH-1:0]  load_tag,
  input  logic                  snoop_en,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_rs_id,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  ready_next,
  output logic [DATA_WIDTH-1:0] value
);

  rs_operand_t op_q, op_d;

  always_comb begin
    op_d = op_q;
    if (load) begin
      op_d.ready = load_ready;
      op_d.tag   = CDB_TAG_WIDTH'(load_tag);
      op_d.value = RS_VALUE_WIDTH'(load_value);
    end
    // The match uses the freshly loaded tag, so a same-cycle broadcast is not lost.
    if ((load || snoop_en) && !op_d.ready && cdb_valid &&
        (op_d.tag == CDB_TAG_WIDTH'(cdb_rs_id))) begin
      op_d.ready = 1'b1;
      op_d.value = RS_VALUE_WIDTH'(cdb_result);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  assign ready_next = op_d.ready;
  assign value      = op_q.value[DATA_WIDTH-1:0];

endmodule

// File: rtl/cdb_reservation_station.sv
// Single-entry reservation station between the dispatcher, its FU and the CDB arbiter.
// Define RS_BACK_TO_BACK_EN to accept a new dispatch in the same cycle the result retires.
module cdb_reservation_station
  import cdb_reservation_station_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RS_ID      = 0,
  parameter int TAG_WIDTH  = 3,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic [OP_WIDTH-1:0]   dispatch_op,
  input  logic                  dispatch_a_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_a_value,
  input  logic [TAG_WIDTH-1:0]  dispatch_a_tag,
  input  logic                  dispatch_b_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_b_value,
  input  logic [TAG_WIDTH-1:0]  dispatch_b_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_rs_id,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  fu_start,
  output logic [OP_WIDTH-1:0]   fu_op,
  output logic [DATA_WIDTH-1:0] fu_operand_a,
  output logic [DATA_WIDTH-1:0] fu_operand_b,
  input  logic                  fu_done,
  input  logic [DATA_WIDTH-1:0] fu_result,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  input  logic                  retire
);

  if (RS_ID >= (1 << TAG_WIDTH)) begin : g_bad_rs_id
    $error("RS_ID does not fit in TAG_WIDTH bits");
  end

  rs_state_t             state_q, state_d;
  logic                  fu_start_q, fu_start_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] result_data_q, result_data_d;
  logic                  result_valid_q, result_valid_d;
  logic                  dispatch_ready_q, dispatch_ready_d;
  logic                  accept;
  logic                  snoop_en;
  logic                  a_ready_d, b_ready_d;

`ifdef RS_BACK_TO_BACK_EN
  assign dispatch_ready = dispatch_ready_q || ((state_q == RESULT) && retire);
`else
  assign dispatch_ready = dispatch_ready_q;
`endif

  assign accept   = dispatch_valid && dispatch_ready;
  assign snoop_en = (state_q == WAIT_OPS);

  rs_operand_capture #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_operand_a (
    .clk(clk), .rst(rst), .load(accept), .load_ready(dispatch_a_ready),
    .load_value(dispatch_a_value), .load_tag(dispatch_a_tag), .snoop_en(snoop_en),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .ready_next(a_ready_d), .value(fu_operand_a)
  );

  rs_operand_capture #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_operand_b (
    .clk(clk), .rst(rst), .load(accept), .load_ready(dispatch_b_ready),
    .load_value(dispatch_b_value), .load_tag(dispatch_b_tag), .snoop_en(snoop_en),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .ready_next(b_ready_d), .value(fu_operand_b)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    result_data_d = result_data_q;
    case (state_q)
      IDLE:     ;
      WAIT_OPS: if (a_ready_d && b_ready_d) state_d = EXEC;
      EXEC: begin
        if (fu_done) begin
          state_d       = RESULT;
          result_data_d = fu_result;
        end
      end
      RESULT:   if (retire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A dispatch can only be accepted from IDLE or a retiring RESULT.
    if (accept) begin
      op_d    = dispatch_op;
      state_d = (a_ready_d && b_ready_d) ? EXEC : WAIT_OPS;
    end
    fu_start_d       = (state_d == EXEC) && (state_q != EXEC);
    result_valid_d   = (state_d == RESULT);
    dispatch_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      fu_start_q       <= 1'b0;
      op_q             <= '0;
      result_data_q    <= '0;
      result_valid_q   <= 1'b0;
      dispatch_ready_q <= 1'b1;
    end else begin
      state_q          <= state_d;
      fu_start_q       <= fu_start_d;
      op_q             <= op_d;
      result_data_q    <= result_data_d;
      result_valid_q   <= result_valid_d;
      dispatch_ready_q <= dispatch_ready_d;
    end
  end

  assign fu_start     = fu_start_q;
  assign fu_op        = op_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;

endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed self-checking bench for cdb_reservation_station (default parameters).
// Define RS_BACK_TO_BACK_EN for both bench and RTL to exercise back-to-back dispatch.
module tb_cdb_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [3:0]  dispatch_op;
  logic        dispatch_a_ready;
  logic [63:0] dispatch_a_value;
  logic [2:0]  dispatch_a_tag;
  logic        dispatch_b_ready;
  logic [63:0] dispatch_b_value;
  logic [2:0]  dispatch_b_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_rs_id;
  logic [63:0] cdb_result;
  logic        fu_start;
  logic [3:0]  fu_op;
  logic [63:0] fu_operand_a;
  logic [63:0] fu_operand_b;
  logic        fu_done;
  logic [63:0] fu_result;
  logic        result_valid;
  logic [63:0] result_data;
  logic        retire;

  int checks   = 0;
  int failures = 0;

  cdb_reservation_station dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_op(dispatch_op),
    .dispatch_a_ready(dispatch_a_ready), .dispatch_a_value(dispatch_a_value), .dispatch_a_tag(dispatch_a_tag),
    .dispatch_b_ready(dispatch_b_ready), .dispatch_b_value(dispatch_b_value), .dispatch_b_tag(dispatch_b_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .fu_start(fu_start), .fu_op(fu_op), .fu_operand_a(fu_operand_a), .fu_operand_b(fu_operand_b),
    .fu_done(fu_done), .fu_result(fu_result),
    .result_valid(result_valid), .result_data(result_data), .retire(retire)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setDispatch(input logic [3:0] op,
                             input logic ar, input logic [63:0] av, input logic [2:0] at,
                             input logic br, input logic [63:0] bv, input logic [2:0] bt);
    dispatch_valid   = 1'b1;
    dispatch_op      = op;
    dispatch_a_ready = ar;
    dispatch_a_value = av;
    dispatch_a_tag   = at;
    dispatch_b_ready = br;
    dispatch_b_value = bv;
    dispatch_b_tag   = bt;
  endtask

  initial begin
    rst = 1'b1;
    dispatch_valid = 1'b0; dispatch_op = '0;
    dispatch_a_ready = 1'b0; dispatch_a_value = '0; dispatch_a_tag = '0;
    dispatch_b_ready = 1'b0; dispatch_b_value = '0; dispatch_b_tag = '0;
    cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0;
    fu_done = 1'b0; fu_result = '0; retire = 1'b0;

    #3;
    checkOutput("reset_dispatch_ready", {63'd0, dispatch_ready}, 64'd1);
    checkOutput("reset_fu_start", {63'd0, fu_start}, 64'd0);
    checkOutput("reset_result_valid", {63'd0, result_valid}, 64'd0);
    checkOutput("reset_result_data", result_data, 64'd0);
    checkOutput("reset_operand_a", fu_operand_a, 64'd0);
    applyStimulus();
    rst = 1'b0;

    // Both operands ready: fu_start one cycle after dispatch, request one after fu_done.
    setDispatch(4'd3, 1'b1, 64'd5, 3'd0, 1'b1, 64'd7, 3'd0);
    applyStimulus();
    dispatch_valid = 1'b0;
    checkOutput("t1_fu_start", {63'd0, fu_start}, 64'd1);
    checkOutput("t1_fu_op", {60'd0, fu_op}, 64'd3);
    checkOutput("t1_operand_a", fu_operand_a, 64'd5);
    checkOutput("t1_operand_b", fu_operand_b, 64'd7);
    checkOutput("t1_dispatch_ready_busy", {63'd0, dispatch_ready}, 64'd0);
    fu_done = 1'b1; fu_result = 64'd12;
    applyStimulus();
    fu_done = 1'b0;
    checkOutput("t1_fu_start_pulse", {63'd0, fu_start}, 64'd0);
    checkOutput("t1_result_valid", {63'd0, result_valid}, 64'd1);
    checkOutput("t1_result_data", result_data, 64'd12);
    retire = 1'b1;
    applyStimulus();
    retire = 1'b0;
    checkOutput("t1_retired_valid", {63'd0, result_valid}, 64'd0);
    checkOutput("t1_retired_ready", {63'd0, dispatch_ready}, 64'd1);

    // Operand A waits on tag 2; a tag-4 broadcast must not be captured.
    setDispatch(4'd1, 1'b0, 64'd0, 3'd2, 1'b1, 64'd9, 3'd0);
    applyStimulus();
    dispatch_valid = 1'b0;
    checkOutput("t2_wait_no_start", {63'd0, fu_start}, 64'd0);
    cdb_valid = 1'b1; cdb_rs_id = 3'd4; cdb_result = 64'h55;
    applyStimulus();
    checkOutput("t2_wrong_tag_no_start", {63'd0, fu_start}, 64'd0);
    cdb_rs_id = 3'd2; cdb_result = 64'hAA;
    applyStimulus();
    cdb_valid = 1'b0;
    checkOutput("t2_fu_start", {63'd0, fu_start}, 64'd1);
    checkOutput("t2_operand_a", fu_operand_a, 64'hAA);
    checkOutput("t2_operand_b", fu_operand_b, 64'd9);
    fu_done = 1'b1; fu_result = 64'h1234;
    applyStimulus();
    checkOutput("t2_result_valid", {63'd0, result_valid}, 64'd1);

    // Hold in RESULT: spurious fu_done and broadcasts change nothing.
    fu_result = 64'hDEAD;
    cdb_valid = 1'b1; cdb_rs_id = 3'd2; cdb_result = 64'hBEEF;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("t4_hold_valid", {63'd0, result_valid}, 64'd1);
      checkOutput("t4_hold_data", result_data, 64'h1234);
      checkOutput("t4_hold_ready", {63'd0, dispatch_ready}, 64'd0);
    end
    fu_done = 1'b0; cdb_valid = 1'b0;
    checkOutput("t4_operand_a_frozen", fu_operand_a, 64'hAA);
    retire = 1'b1;
    applyStimulus();
    retire = 1'b0;
    checkOutput("t4_retired_ready", {63'd0, dispatch_ready}, 64'd1);

    // Same-cycle bypass into both operands from one broadcast.
    setDispatch(4'd5, 1'b0, 64'd0, 3'd1, 1'b0, 64'd0, 3'd1);
    cdb_valid = 1'b1; cdb_rs_id = 3'd1; cdb_result = 64'h10;
    applyStimulus();
    dispatch_valid = 1'b0; cdb_valid = 1'b0;
    checkOutput("t3_bypass_start", {63'd0, fu_start}, 64'd1);
    checkOutput("t3_bypass_a", fu_operand_a, 64'h10);
    checkOutput("t3_bypass_b", fu_operand_b, 64'h10);
    checkOutput("t3_fu_op", {60'd0, fu_op}, 64'd5);

    // Asynchronous reset while in EXEC; a later fu_done is ignored.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_fu_start", {63'd0, fu_start}, 64'd0);
    checkOutput("t5_rst_ready", {63'd0, dispatch_ready}, 64'd1);
    checkOutput("t5_rst_operand_a", fu_operand_a, 64'd0);
    rst = 1'b0;
    fu_done = 1'b1; fu_result = 64'h77;
    applyStimulus();
    fu_done = 1'b0;
    checkOutput("t5_late_done_valid", {63'd0, result_valid}, 64'd0);
    checkOutput("t5_late_done_data", result_data, 64'd0);

    // Reach RESULT again for the retire-cycle dispatch behaviour.
    setDispatch(4'd2, 1'b1, 64'd1, 3'd0, 1'b1, 64'd2, 3'd0);
    applyStimulus();
    dispatch_valid = 1'b0;
    fu_done = 1'b1; fu_result = 64'h99;
    applyStimulus();
    fu_done = 1'b0;
    checkOutput("t6_result_data", result_data, 64'h99);
    retire = 1'b1;
    setDispatch(4'd6, 1'b0, 64'd0, 3'd0, 1'b1, 64'd4, 3'd0);
    cdb_valid = 1'b1; cdb_rs_id = 3'd0; cdb_result = 64'h33;
    #1;
`ifdef RS_BACK_TO_BACK_EN
    checkOutput("t6_b2b_ready", {63'd0, dispatch_ready}, 64'd1);
    applyStimulus();
    retire = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0;
    checkOutput("t6_b2b_fu_start", {63'd0, fu_start}, 64'd1);
    checkOutput("t6_b2b_operand_a", fu_operand_a, 64'h33);
    checkOutput("t6_b2b_operand_b", fu_operand_b, 64'd4);
    checkOutput("t6_b2b_result_valid", {63'd0, result_valid}, 64'd0);
`else
    checkOutput("t6_retire_ready", {63'd0, dispatch_ready}, 64'd0);
    applyStimulus();
    retire = 1'b0; cdb_valid = 1'b0;
    checkOutput("t6_not_accepted", {63'd0, fu_start}, 64'd0);
    checkOutput("t6_idle_ready", {63'd0, dispatch_ready}, 64'd1);
    dispatch_a_ready = 1'b1; dispatch_a_value = 64'h21;
    applyStimulus();
    dispatch_valid = 1'b0;
    checkOutput("t6_next_fu_start", {63'd0, fu_start}, 64'd1);
    checkOutput("t6_next_operand_a", fu_operand_a, 64'h21);
    checkOutput("t6_next_fu_op", {60'd0, fu_op}, 64'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
